ex_mem_stage: RTL and testbench

//   EX->MEM pipeline register and branch-resolution stage, directly downstream of the ALU.

---
 rtl/ex_mem_stage.sv | 111 +++++++++++
 tb/tb_ex_mem_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch/jump resolution.
// This stage registers the ALU result and the EX control fields into the MEM
// stage. It turns a taken BEQ/BNE/BLT/BGE/JAL/JALR into a one-cycle redirect
// pulse for fetch. It also squashes the single wrong-path instruction that sits
// in EX while that redirect is in flight.
module ex_mem_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_stall,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_branch,
  input  logic              ex_is_jal,
  input  logic              ex_is_jalr,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_bcond,
  output logic              mem_valid,
  output logic [XLEN-1:0]   mem_result,
  output logic [XLEN-1:0]   mem_rs2_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_reg_write,
  output logic              mem_mem_to_reg,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

  // RUN: normal capture. SQUASH: a stall froze the wrong-path EX slot
  // while the redirect pulse was out, so the next capture must be dropped.
  typedef enum logic {RUN, SQUASH} state_t;

  state_t          state;
  logic            squash;
  logic            slot_valid;
  logic            is_jump;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link_value;

  // JALR clears bit 0 of the ALU sum. Branches and JAL are PC-relative.
  // Both targets wrap modulo 2^XLEN.
  function automatic logic [XLEN-1:0] redirect_target(
    input logic            jalr,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] alu
  );
    if (jalr) return alu & ~XLEN'(1);
    return pc + imm;
  endfunction

  // Decide what the current EX slot turns into if it is captured this cycle.
  // While the pulse is high, EX holds the instruction fetched down the wrong path.
  always_comb begin
    squash     = redirect_valid | (state == SQUASH);
    slot_valid = ex_valid & ~squash;
    is_jump    = ex_is_jal | ex_is_jalr;
    taken      = slot_valid & (is_jump | (ex_is_branch & alu_bcond));
    target     = redirect_target(ex_is_jalr, ex_pc, ex_imm, alu_result);
    link_value = is_jump ? (ex_pc + INSN_BYTES) : alu_result;
  end

  // This block holds the pipeline register, the redirect pulse and the squash FSM.
  // A stall freezes every MEM-side output but always drops the pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= RUN;
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_rs2_data   <= '0;
      mem_rd         <= '0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      if (!mem_stall) begin
        mem_valid      <= slot_valid;
        mem_result     <= link_value;
        mem_rs2_data   <= ex_rs2_data;
        mem_rd         <= ex_rd;
        mem_mem_read   <= slot_valid & ex_mem_read;
        mem_mem_write  <= slot_valid & ex_mem_write;
        mem_reg_write  <= slot_valid & ex_reg_write & ~ex_is_branch;
        mem_mem_to_reg <= slot_valid & ex_mem_to_reg;
        redirect_valid <= taken;
        if (taken) redirect_pc <= target;
        state          <= RUN;
      end else if (redirect_valid) begin
        state <= SQUASH;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage. The bench runs directed scenarios and then random
// traffic against a transaction-level model. The driver pushes the expected
// post-edge outputs into a queue. A separate monitor pops that queue and compares.
module tb_ex_mem_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset_n, mem_stall, ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs2_data, alu_result;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_branch, ex_is_jal, ex_is_jalr;
  logic              ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, alu_bcond;
  logic              mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
  logic [XLEN-1:0]   mem_result, mem_rs2_data, redirect_pc;
  logic [REG_AW-1:0] mem_rd;
  logic              redirect_valid;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset_n(reset_n), .mem_stall(mem_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .alu_result(alu_result), .alu_bcond(alu_bcond),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rs2_data(mem_rs2_data),
    .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic              rst_n, stall, v;
    logic [XLEN-1:0]   pc, imm, rs2, alu;
    logic [REG_AW-1:0] rd;
    logic              br, jal, jalr, mr, mw, rw, m2r, bcond;
  } stim_t;

  typedef struct {
    logic              valid;
    logic [XLEN-1:0]   result, rs2, rpc;
    logic [REG_AW-1:0] rd;
    logic              mr, mw, rw, m2r, rv;
    logic              data_known, rpc_known;
  } exp_t;

  exp_t  q[$];
  exp_t  cur;
  bit    wrong_path_next;  // the next instruction accepted from EX is wrong-path
  int    checks = 0;
  int    passes = 0;
  stim_t s;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
  endtask

  function automatic stim_t idle();
    stim_t r;
    r = '{default: '0};
    r.rst_n = 1'b1;
    return r;
  endfunction

  // Apply one cycle of stimulus and predict the outputs after the next edge.
  task automatic apply_step(input stim_t t);
    logic v, jump, tk;
    @(negedge clk);
    reset_n = t.rst_n; mem_stall = t.stall; ex_valid = t.v;
    ex_pc = t.pc; ex_imm = t.imm; ex_rs2_data = t.rs2; ex_rd = t.rd;
    ex_is_branch = t.br; ex_is_jal = t.jal; ex_is_jalr = t.jalr;
    ex_mem_read = t.mr; ex_mem_write = t.mw; ex_reg_write = t.rw;
    ex_mem_to_reg = t.m2r; alu_result = t.alu; alu_bcond = t.bcond;
    if (!t.rst_n) begin
      cur = '{default: '0};
      cur.data_known = 1'b1;
      cur.rpc_known  = 1'b1;
      wrong_path_next = 1'b0;
    end else if (t.stall) begin
      cur.rv = 1'b0;
    end else begin
      v    = t.v && !wrong_path_next;
      jump = t.jal || t.jalr;
      tk   = v && (jump || (t.br && t.bcond));
      cur.valid  = v;
      cur.result = jump ? t.pc + 32'd4 : t.alu;
      cur.rs2    = t.rs2;
      cur.rd     = t.rd;
      cur.mr     = v && t.mr;
      cur.mw     = v && t.mw;
      cur.rw     = v && t.rw && !t.br;
      cur.m2r    = v && t.m2r;
      cur.rv     = tk;
      cur.data_known = v;
      cur.rpc_known  = tk;
      if (tk) cur.rpc = t.jalr ? (t.alu & ~32'd1) : t.pc + t.imm;
      wrong_path_next = tk;
    end
    q.push_back(cur);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: after every edge, compare the DUT against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mem_valid", 32'(mem_valid), 32'(e.valid));
        chk("mem_mem_read", 32'(mem_mem_read), 32'(e.mr));
        chk("mem_mem_write", 32'(mem_mem_write), 32'(e.mw));
        chk("mem_reg_write", 32'(mem_reg_write), 32'(e.rw));
        chk("mem_mem_to_reg", 32'(mem_mem_to_reg), 32'(e.m2r));
        chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        if (e.data_known) begin
          chk("mem_result", mem_result, e.result);
          chk("mem_rs2_data", mem_rs2_data, e.rs2);
          chk("mem_rd", 32'(mem_rd), 32'(e.rd));
        end
        if (e.rpc_known) chk("redirect_pc", redirect_pc, e.rpc);
      end
    end
  end

  initial begin
    int kind;
    reset_n = 1'b0; mem_stall = 1'b0; ex_valid = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_rs2_data = '0; ex_rd = '0;
    ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
    ex_mem_to_reg = 1'b0; alu_result = '0; alu_bcond = 1'b0;
    cur = '{default: '0};
    wrong_path_next = 1'b0;

    // Reset while EX is valid
    s = idle(); s.rst_n = 1'b0; s.v = 1'b1; s.alu = 32'hDEAD_BEEF; s.rw = 1'b1; s.mr = 1'b1;
    apply_step(s); after_edge();
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("reset_mem_result", mem_result, 32'd0);
    chk("reset_redirect", 32'(redirect_valid), 32'd0);

    // ADD after reset release
    s = idle(); s.v = 1'b1; s.alu = 32'h10; s.rd = 5'd5; s.rw = 1'b1;
    apply_step(s); after_edge();
    chk("add_valid", 32'(mem_valid), 32'd1);
    chk("add_result", mem_result, 32'h10);
    chk("add_rd", 32'(mem_rd), 32'd5);
    chk("add_redirect", 32'(redirect_valid), 32'd0);

    // Taken BEQ, then the wrong-path follower
    s = idle(); s.v = 1'b1; s.br = 1'b1; s.bcond = 1'b1; s.pc = 32'h100; s.imm = 32'h20;
    apply_step(s); after_edge();
    chk("beq_redirect", 32'(redirect_valid), 32'd1);
    chk("beq_target", redirect_pc, 32'h120);
    chk("beq_no_regwrite", 32'(mem_reg_write), 32'd0);
    s = idle(); s.v = 1'b1; s.alu = 32'h55; s.rw = 1'b1;
    apply_step(s); after_edge();
    chk("beq_follower_squashed", 32'(mem_valid), 32'd0);
    chk("beq_pulse_once", 32'(redirect_valid), 32'd0);

    // JALR, wrong-path follower, then not-taken BNE
    s = idle(); s.v = 1'b1; s.jalr = 1'b1; s.alu = 32'h203; s.pc = 32'h40; s.rw = 1'b1; s.rd = 5'd1;
    apply_step(s); after_edge();
    chk("jalr_target", redirect_pc, 32'h202);
    chk("jalr_link", mem_result, 32'h44);
    chk("jalr_regwrite", 32'(mem_reg_write), 32'd1);
    s = idle(); s.v = 1'b1;
    apply_step(s);
    s = idle(); s.v = 1'b1; s.br = 1'b1; s.bcond = 1'b0; s.pc = 32'h80; s.imm = 32'h10;
    apply_step(s); after_edge();
    chk("bne_not_taken", 32'(redirect_valid), 32'd0);
    chk("bne_valid", 32'(mem_valid), 32'd1);

    // Taken JAL with a three-cycle stall during the redirect cycle
    s = idle(); s.v = 1'b1; s.jal = 1'b1; s.pc = 32'h200; s.imm = 32'h40; s.rw = 1'b1; s.rd = 5'd2;
    apply_step(s);
    s = idle(); s.stall = 1'b1; s.v = 1'b1;
    repeat (3) apply_step(s);
    after_edge();
    chk("jal_stall_pulse_gone", 32'(redirect_valid), 32'd0);
    chk("jal_stall_hold_result", mem_result, 32'h204);
    chk("jal_stall_hold_target", redirect_pc, 32'h240);
    s = idle(); s.v = 1'b1; s.jal = 1'b1; s.pc = 32'h300; s.rw = 1'b1;
    apply_step(s); after_edge();
    chk("post_stall_squashed", 32'(mem_valid), 32'd0);
    chk("post_stall_no_refire", 32'(redirect_valid), 32'd0);

    // Wrap-around JAL, stall into SQUASH, then reset
    s = idle(); s.v = 1'b1; s.jal = 1'b1; s.pc = 32'hFFFF_FFFC; s.imm = 32'h8; s.rw = 1'b1;
    apply_step(s); after_edge();
    chk("wrap_target", redirect_pc, 32'h4);
    chk("wrap_link", mem_result, 32'h0);
    s = idle(); s.stall = 1'b1; s.v = 1'b1;
    apply_step(s);
    s = idle(); s.rst_n = 1'b0; s.stall = 1'b1; s.v = 1'b1;
    apply_step(s); after_edge();
    chk("squash_reset_valid", 32'(mem_valid), 32'd0);
    chk("squash_reset_pc", redirect_pc, 32'd0);
    s = idle(); s.v = 1'b1; s.alu = 32'h77; s.rw = 1'b1;
    apply_step(s); after_edge();
    chk("after_reset_run", 32'(mem_valid), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 39) != 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.v     = ($urandom_range(0, 5) != 0);
      s.pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      s.imm   = $urandom; s.alu = $urandom; s.rs2 = $urandom;
      s.rd    = REG_AW'($urandom);
      s.rw    = 1'($urandom); s.m2r = 1'($urandom); s.bcond = 1'($urandom);
      kind    = $urandom_range(0, 5);
      case (kind)
        2: s.br = 1'b1;
        3: s.jal = 1'b1;
        4: s.jalr = 1'b1;
        5: begin s.mr = 1'($urandom); s.mw = !s.mr; end
        default: ;
      endcase
      apply_step(s);
    end
    s = idle();
    apply_step(s);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #3;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: %0d predictions left, expected 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
